// File: rtl/noc_pe_iface.sv
// Network interface between a PE/memory core and one mesh router pe_mem port.
// TX: packs core transfers into packets through a circular FIFO. RX: filters by destination into a one-entry holding register.
module noc_pe_iface #(
    parameter int unsigned WIDTH_PACKAGE = 33,
    parameter logic [4:0]  ROUTER_LOC    = 5'b000_00,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     core_tx_valid,
    output logic                     core_tx_ready,
    input  logic [4:0]               core_tx_dest,
    input  logic [2:0]               core_tx_type,
    input  logic [19:0]              core_tx_data,
    output logic                     net_tx_valid,
    input  logic                     net_tx_ready,
    output logic [WIDTH_PACKAGE-1:0] net_tx_pkt,
    input  logic                     net_rx_valid,
    output logic                     net_rx_ready,
    input  logic [WIDTH_PACKAGE-1:0] net_rx_pkt,
    output logic                     core_rx_valid,
    input  logic                     core_rx_ready,
    output logic [4:0]               core_rx_src,
    output logic [2:0]               core_rx_type,
    output logic [19:0]              core_rx_data,
    output logic [7:0]               drop_count
);

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned TYPE_W   = 3;
    localparam int unsigned DATA_W   = 20;
    localparam int unsigned DROP_W   = 8;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] src;
        logic [TYPE_W-1:0] ptype;
        logic [DATA_W-1:0] data;
    } pkt_t;

    localparam int unsigned PKT_W = $bits(pkt_t);

    // ---------------- TX path ----------------
    pkt_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_valid_q, tx_valid_d;
    logic             push;
    logic             pop;
    pkt_t             tx_pkt;

    assign push = core_tx_valid && tx_ready_q;
    assign pop  = tx_valid_q && net_tx_ready;

    always_comb begin
        tx_pkt       = '0;
        tx_pkt.dest  = core_tx_dest;
        tx_pkt.src   = ROUTER_LOC;
        tx_pkt.ptype = core_tx_type;
        tx_pkt.data  = core_tx_data;
    end

    // Ready/valid flags are registered from next-state count so full/empty never loop back combinationally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        tx_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        tx_valid_d = (count_d != CNT_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_ready_q <= tx_ready_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_pkt;
        end
    end

    assign core_tx_ready = tx_ready_q;
    assign net_tx_valid  = tx_valid_q;
    assign net_tx_pkt    = WIDTH_PACKAGE'(mem_q[rd_ptr_q]);

    // ---------------- RX path ----------------
    pkt_t              rx_pkt;
    logic              hv_q, hv_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              rx_accept;
    logic              rx_match;
    logic              rx_take;

    assign rx_pkt       = pkt_t'(net_rx_pkt[PKT_W-1:0]);
    assign net_rx_ready = !hv_q || core_rx_ready;
    assign rx_accept    = net_rx_valid && net_rx_ready;
    assign rx_match     = (rx_pkt.dest == ROUTER_LOC);
    assign rx_take      = hv_q && core_rx_ready;

    // A matching load wins over a same-cycle take so drain+refill keeps the register full.
    always_comb begin
        hv_d   = hv_q;
        src_d  = src_q;
        type_d = type_q;
        data_d = data_q;
        drop_d = drop_q;
        if (rx_accept && rx_match) begin
            hv_d   = 1'b1;
            src_d  = rx_pkt.src;
            type_d = rx_pkt.ptype;
            data_d = rx_pkt.data;
        end else if (rx_take) begin
            hv_d = 1'b0;
        end
        if (rx_accept && !rx_match && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q   <= 1'b0;
            src_q  <= '0;
            type_q <= '0;
            data_q <= '0;
            drop_q <= '0;
        end else begin
            hv_q   <= hv_d;
            src_q  <= src_d;
            type_q <= type_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    assign core_rx_valid = hv_q;
    assign core_rx_src   = src_q;
    assign core_rx_type  = type_q;
    assign core_rx_data  = data_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_noc_pe_iface.sv
// Scoreboard bench for noc_pe_iface: TX/RX expectations queued at input handshakes, compared at output handshakes.
module tb_noc_pe_iface;

    localparam logic [4:0] LOC = 5'b001_01;

    logic        clk;
    logic        rst_n;
    logic        core_tx_valid;
    logic        core_tx_ready;
    logic [4:0]  core_tx_dest;
    logic [2:0]  core_tx_type;
    logic [19:0] core_tx_data;
    logic        net_tx_valid;
    logic        net_tx_ready;
    logic [32:0] net_tx_pkt;
    logic        net_rx_valid;
    logic        net_rx_ready;
    logic [32:0] net_rx_pkt;
    logic        core_rx_valid;
    logic        core_rx_ready;
    logic [4:0]  core_rx_src;
    logic [2:0]  core_rx_type;
    logic [19:0] core_rx_data;
    logic [7:0]  drop_count;

    noc_pe_iface #(
        .WIDTH_PACKAGE(33),
        .ROUTER_LOC   (LOC),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_tx_valid(core_tx_valid),
        .core_tx_ready(core_tx_ready),
        .core_tx_dest (core_tx_dest),
        .core_tx_type (core_tx_type),
        .core_tx_data (core_tx_data),
        .net_tx_valid (net_tx_valid),
        .net_tx_ready (net_tx_ready),
        .net_tx_pkt   (net_tx_pkt),
        .net_rx_valid (net_rx_valid),
        .net_rx_ready (net_rx_ready),
        .net_rx_pkt   (net_rx_pkt),
        .core_rx_valid(core_rx_valid),
        .core_rx_ready(core_rx_ready),
        .core_rx_src  (core_rx_src),
        .core_rx_type (core_rx_type),
        .core_rx_data (core_rx_data),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tx_pops = 0;
    int exp_drop = 0;
    logic [32:0] tx_q[$];
    logic [27:0] rx_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Samples handshakes 1 time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            if (net_tx_valid && net_tx_ready) begin
                tx_pops++;
                if (tx_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
                else                  check("tx_pkt", 64'(net_tx_pkt), 64'(tx_q.pop_front()));
            end
            if (core_tx_valid && core_tx_ready)
                tx_q.push_back({core_tx_dest, LOC, core_tx_type, core_tx_data});
            if (core_rx_valid && core_rx_ready) begin
                if (rx_q.size() == 0) check("rx_unexpected", 64'd1, 64'd0);
                else check("rx_payload", 64'({core_rx_src, core_rx_type, core_rx_data}),
                           64'(rx_q.pop_front()));
            end
            if (net_rx_valid && net_rx_ready) begin
                if (net_rx_pkt[32:28] == LOC) rx_q.push_back(net_rx_pkt[27:0]);
                else if (exp_drop != 255)     exp_drop++;
            end
        end
    end

    task automatic send_tx(input logic [4:0] dest, input logic [2:0] typ,
                           input logic [19:0] data, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        core_tx_valid = 1'b1;
        core_tx_dest  = dest;
        core_tx_type  = typ;
        core_tx_data  = data;
        for (int n = 0; n < 100; n++) begin
            #4;
            acc = core_tx_ready;
            @(negedge clk);
            waits = n;
            if (acc) break;
        end
        core_tx_valid = 1'b0;
        if (!acc) check("tx_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rx(input logic [4:0] dest, input logic [4:0] src, input logic [2:0] typ,
                           input logic [19:0] data, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        net_rx_valid = 1'b1;
        net_rx_pkt   = {dest, src, typ, data};
        for (int n = 0; n < 100; n++) begin
            #4;
            acc = net_rx_ready;
            @(negedge clk);
            waits = n;
            if (acc) break;
        end
        net_rx_valid = 1'b0;
        if (!acc) check("rx_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int pops0;
        logic [4:0] d;

        rst_n = 1'b0;
        core_tx_valid = 1'b0; core_tx_dest = '0; core_tx_type = '0; core_tx_data = '0;
        net_tx_ready = 1'b0; net_rx_valid = 1'b0; net_rx_pkt = '0; core_rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 64'(net_tx_valid), 64'd0);
        check("rst_tx_ready", 64'(core_tx_ready), 64'd1);
        check("rst_rx_ready", 64'(net_rx_ready), 64'd1);
        check("rst_rx_valid", 64'(core_rx_valid), 64'd0);
        check("rst_rx_fields", 64'({core_rx_src, core_rx_type, core_rx_data}), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single packet with one-cycle latency
        net_tx_ready  = 1'b1;
        core_tx_valid = 1'b1;
        core_tx_dest  = 5'b010_10;
        core_tx_type  = 3'd3;
        core_tx_data  = 20'hABCDE;
        #4;
        check("lat_pre_valid", 64'(net_tx_valid), 64'd0);
        @(negedge clk);
        core_tx_valid = 1'b0;
        check("lat_valid", 64'(net_tx_valid), 64'd1);
        check("lat_pkt", 64'(net_tx_pkt), 64'({5'b01010, 5'b00101, 3'b011, 20'hABCDE}));
        @(negedge clk);
        check("lat_drained", 64'(net_tx_valid), 64'd0);

        // Fill to full, then release
        net_tx_ready = 1'b0;
        pops0 = tx_pops;
        for (int i = 0; i < 4; i++) begin
            send_tx(5'(i + 8), 3'(i), 20'(32'h100 + i), w);
            check("fill_wait", 64'(w), 64'd0);
        end
        check("full_ready", 64'(core_tx_ready), 64'd0);
        repeat (2) @(negedge clk);
        check("full_hold", 64'(core_tx_ready), 64'd0);
        net_tx_ready = 1'b1;
        send_tx(5'd12, 3'd4, 20'h00104, w);
        check("fifth_wait", 64'(w), 64'd1);
        send_tx(5'd13, 3'd5, 20'h00105, w);
        check("sixth_wait", 64'(w), 64'd0);
        repeat (3) @(negedge clk);
        check("fill_empty", 64'(net_tx_valid), 64'd0);
        check("fill_pops", 64'(tx_pops - pops0), 64'd6);

        // Steady push+pop at occupancy 2 across pointer wrap
        net_tx_ready = 1'b0;
        pops0 = tx_pops;
        send_tx(5'd1, 3'd1, 20'h0A001, w);
        send_tx(5'd2, 3'd2, 20'h0A002, w);
        net_tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_tx(5'(i), 3'(i), 20'(32'hB000 + i * 7), w);
            check("cont_wait", 64'(w), 64'd0);
        end
        check("cont_valid2", 64'(net_tx_valid), 64'd1);
        @(negedge clk);
        check("cont_valid1", 64'(net_tx_valid), 64'd1);
        @(negedge clk);
        check("cont_valid0", 64'(net_tx_valid), 64'd0);
        check("cont_pops", 64'(tx_pops - pops0), 64'd12);

        // RX hold, backpressure, then drain+refill
        core_rx_ready = 1'b0;
        send_rx(LOC, 5'b000_10, 3'd1, 20'h00055, w);
        check("rx_valid", 64'(core_rx_valid), 64'd1);
        check("rx_net_ready", 64'(net_rx_ready), 64'd0);
        check("rx_src", 64'(core_rx_src), 64'h02);
        check("rx_data", 64'(core_rx_data), 64'h55);
        fork
            send_rx(LOC, 5'b000_11, 3'd2, 20'h00066, w);
            begin
                repeat (3) @(negedge clk);
                check("rx_hold_valid", 64'(core_rx_valid), 64'd1);
                check("rx_hold_data", 64'(core_rx_data), 64'h55);
                core_rx_ready = 1'b1;
            end
        join
        check("rx_stall_wait", 64'(w), 64'd3);
        check("rx_refill_valid", 64'(core_rx_valid), 64'd1);
        check("rx_refill_data", 64'({core_rx_src, core_rx_data}), 64'({5'b00011, 20'h00066}));
        @(negedge clk);
        check("rx_empty", 64'(core_rx_valid), 64'd0);
        check("rx_held_data", 64'(core_rx_data), 64'h66);

        // Misrouted flood saturates drop counter
        for (int i = 0; i < 300; i++) begin
            d = 5'(i % 32);
            if (d == LOC) d = 5'b111_11;
            send_rx(d, 5'(i), 3'(i), 20'(i), w);
            if (i == 99)  check("drop_mid", 64'(drop_count), 64'(exp_drop));
            if (i == 254) check("drop_255", 64'(drop_count), 64'd255);
        end
        check("drop_sat", 64'(drop_count), 64'd255);
        check("drop_model", 64'(drop_count), 64'(exp_drop));
        check("drop_no_rx", 64'(core_rx_valid), 64'd0);

        // Asynchronous reset with traffic in flight
        net_tx_ready  = 1'b0;
        core_rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_tx(5'd7, 3'd1, 20'(32'hC00 + i), w);
        send_rx(LOC, 5'b010_01, 3'd6, 20'h77777, w);
        check("pre_rst_valid", 64'({net_tx_valid, core_rx_valid}), 64'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 64'(net_tx_valid), 64'd0);
        check("arst_rx_valid", 64'(core_rx_valid), 64'd0);
        check("arst_drop", 64'(drop_count), 64'd0);
        check("arst_rx_data", 64'(core_rx_data), 64'd0);
        check("arst_tx_ready", 64'(core_tx_ready), 64'd1);
        tx_q.delete();
        rx_q.delete();
        exp_drop = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        net_tx_ready  = 1'b1;
        core_tx_valid = 1'b1;
        core_tx_dest  = 5'b111_00;
        core_tx_type  = 3'd7;
        core_tx_data  = 20'h12345;
        @(negedge clk);
        core_tx_valid = 1'b0;
        check("post_rst_valid", 64'(net_tx_valid), 64'd1);
        check("post_rst_pkt", 64'(net_tx_pkt), 64'({5'b11100, 5'b00101, 3'b111, 20'h12345}));
        core_rx_ready = 1'b1;
        send_rx(LOC, 5'b000_01, 3'd2, 20'h0BEEF, w);
        repeat (3) @(negedge clk);
        check("end_tx_q", 64'(tx_q.size()), 64'd0);
        check("end_rx_q", 64'(rx_q.size()), 64'd0);
        check("end_drop", 64'(drop_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_pe_iface.md
Name: noc_pe_iface

Overview:
- Synchronous network interface between a clocked PE/memory core and the pe_mem port of one mesh router.
- TX path: packs core transfers (dest, type, payload) into WIDTH_PACKAGE-bit packets, buffers them in a FIFO, and presents them to the router-side channel adapter.
- RX path: accepts packets from the router, checks the destination field against ROUTER_LOC, and delivers matching payloads to the core through a one-entry holding register.
- Misrouted packets are dropped and counted.

Parameters:
- WIDTH_PACKAGE, 33: packet width; fixed layout below.
- ROUTER_LOC, 5'b000_00: this node's address, {x[2:0], y[1:0]}.
- FIFO_DEPTH, 4: TX FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- core_tx_valid  in  1  core offers a transfer.
- core_tx_ready  out  1  interface accepts the transfer.
- core_tx_dest  in  5  destination router address.
- core_tx_type  in  3  packet type code.
- core_tx_data  in  20  payload.
- net_tx_valid  out  1  packet available to router adapter.
- net_tx_ready  in  1  router adapter takes packet.
- net_tx_pkt  out  33  outgoing packet.
- net_rx_valid  in  1  router adapter offers packet.
- net_rx_ready  out  1  interface accepts packet.
- net_rx_pkt  in  33  incoming packet.
- core_rx_valid  out  1  payload available to core.
- core_rx_ready  in  1  core takes payload.
- core_rx_src  out  5  source field of delivered packet.
- core_rx_type  out  3  type field.
- core_rx_data  out  20  payload.
- drop_count  out  8  misrouted packets dropped; saturates at 255.

Behaviour:
- Packet layout: [32:28] dest, [27:23] src, [22:20] type, [19:0] data.
- TX packing: src is always ROUTER_LOC.
- Handshakes: a transfer occurs on a rising clk edge when valid && ready. Valid, once asserted, holds with stable data until the transfer; the block guarantees this on its outputs.
- Reset (asynchronous, any time, including mid-transfer): FIFO emptied; net_tx_valid=0; core_rx_valid=0; core_rx_src/type/data=0; drop_count=0; core_tx_ready=1; net_rx_ready=1. In-flight packets are discarded.
- TX FIFO:
  - Circular buffer; read/write pointers log2(FIFO_DEPTH) bits, wrap to 0; count is 0..FIFO_DEPTH.
  - core_tx_ready = (count != FIFO_DEPTH).
  - net_tx_valid = (count != 0).
  - net_tx_pkt = entry at read pointer, driven from registers.
  - Latency: core accept at edge N -> net_tx_valid high after edge N when the FIFO was empty. No combinational path from core_tx_* to net_tx_*.
  - Simultaneous push and pop: count unchanged, both pointers advance. When full, a simultaneous pop does not enable a same-cycle push, because core_tx_ready is computed from count only.
  - Order is preserved strictly FIFO.
- RX path:
  - Single holding register hv (drives core_rx_valid).
  - net_rx_ready = !hv || core_rx_ready; a same-cycle drain+refill gives full throughput.
  - On net accept with pkt[32:28]==ROUTER_LOC: load src/type/data; hv=1.
  - On net accept with pkt[32:28]!=ROUTER_LOC: packet dropped, hv is unaffected by it, drop_count += 1 unless already 255.
  - On core take with no matching load in the same cycle: hv=0. Outputs keep their last values while hv=0.
  - Latency: net accept at edge N -> core_rx_valid high after edge N.
- TX and RX paths are fully independent. A self-addressed TX packet (dest==ROUTER_LOC) is sent normally, with no local loopback.

Test Plan:
- Reset, then ROUTER_LOC=5'b001_01, send dest=5'b010_10, type=3, data=20'hABCDE with net_tx_ready=1 -> net_tx_pkt=33'b01010_00101_011_{20'hABCDE}, net_tx_valid high exactly one cycle after accept.
- Hold net_tx_ready=0 and offer 6 transfers (FIFO_DEPTH=4) -> core_tx_ready drops after the 4th accept. Release ready -> 4 packets emitted in order, one per cycle. The 5th is accepted on the cycle after the first pop.
- Continuous push+pop with FIFO at count=2 for 10 cycles -> count stays 2, no loss, no reorder across pointer wrap.
- RX packet with dest=ROUTER_LOC, src=5'b000_10, data=20'h00055 and core_rx_ready=0 -> core_rx_valid=1 and held, net_rx_ready=0. Next packet stalls until core_rx_ready=1, then the back-to-back packet is delivered in the following cycle.
- 300 packets with dest!=ROUTER_LOC -> no core_rx_valid; drop_count reaches 255 and stays 255.
- Assert rst_n low mid-cycle with FIFO count=3 and hv=1 -> immediately (before the next edge) net_tx_valid=0, core_rx_valid=0, drop_count=0. After release, the first new transfer emerges as the first packet.
